bm_stripe_encoder: RTL and testbench

Pipelined, parametrised bitmatrix erasure-coding engine. It streams the K data-device chunks of a stripe, each chunk being W packets of PACKET_LENGTH bits. For each chunk it computes the GF(2^W) bitmatrix product for all M parity rows in parallel and XOR-accumulates the products across the stripe. It emits the M parity chunks with valid/ready flow control and sits between the data-fetch buffer and the parity write-back path of the engine.

---
 rtl/ec_pkg.sv | 24 ++
 rtl/bm_row_mult.sv | 24 ++
 rtl/bm_stripe_encoder.sv | 102 ++++++++++
 tb/tb_bm_stripe_encoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ec_pkg.sv
// Shared defaults, payload typedefs and flattening index helpers for the bitmatrix erasure-coding engine.
package ec_pkg;

    localparam int unsigned W_DEF             = 8;
    localparam int unsigned PACKET_LENGTH_DEF = 32;
    localparam int unsigned K_DEF             = 4;
    localparam int unsigned M_DEF             = 2;

    typedef logic [PACKET_LENGTH_DEF-1:0] packet_t;
    typedef packet_t [W_DEF-1:0]          chunk_t;

    // Bit position of coefficient (data packet i -> parity r, packet j) in a flattened bitmatrix.
    function automatic int unsigned bm_bit(input int unsigned r, input int unsigned j,
                                           input int unsigned i, input int unsigned w);
        return (r * w + j) * w + i;
    endfunction

    // LSB of parity r, packet j in a flattened parity vector.
    function automatic int unsigned par_lsb(input int unsigned r, input int unsigned j,
                                            input int unsigned w, input int unsigned pl);
        return (r * w + j) * pl;
    endfunction

endpackage

// File: rtl/bm_row_mult.sv
// One parity row: W x W bitmatrix block times a W-packet chunk over GF(2) (AND/XOR only).
module bm_row_mult
    import ec_pkg::*;
#(
    parameter int unsigned W             = W_DEF,
    parameter int unsigned PACKET_LENGTH = PACKET_LENGTH_DEF
) (
    input  logic [W*PACKET_LENGTH-1:0] data,
    input  logic [W*W-1:0]             bm,
    output logic [W*PACKET_LENGTH-1:0] prod_c
);

    always_comb begin
        prod_c = '0;
        for (int unsigned j = 0; j < W; j++) begin
            for (int unsigned i = 0; i < W; i++) begin
                prod_c[par_lsb(0, j, W, PACKET_LENGTH) +: PACKET_LENGTH] ^=
                    data[i*PACKET_LENGTH +: PACKET_LENGTH] &
                    {PACKET_LENGTH{bm[bm_bit(0, j, i, W)]}};
            end
        end
    end

endmodule

// File: rtl/bm_stripe_encoder.sv
// Streams K data chunks per stripe, multiplies each by M bitmatrix rows in parallel and
// XOR-accumulates the products into M parity chunks handed off with valid/ready.
module bm_stripe_encoder
    import ec_pkg::*;
#(
    parameter int unsigned W             = W_DEF,
    parameter int unsigned PACKET_LENGTH = PACKET_LENGTH_DEF,
    parameter int unsigned K             = K_DEF,
    parameter int unsigned M             = M_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W*PACKET_LENGTH-1:0]   in_data,
    input  logic [M*W*W-1:0]             in_bm,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [M*W*PACKET_LENGTH-1:0] out_parity,
    output logic [15:0]                  out_stripe_cnt
);

    localparam int unsigned CW    = W * PACKET_LENGTH;
    localparam int unsigned PW    = M * CW;
    localparam int unsigned CNT_W = (K > 1) ? $clog2(K) : 1;

    logic [CNT_W-1:0] beat_cnt;
    logic             s1_valid;
    logic             s1_last;
    logic             s1_first;
    logic [PW-1:0]    s1_prod;
    logic [PW-1:0]    acc;

    logic [PW-1:0]    prod_c;
    logic [PW-1:0]    acc_next_c;
    logic             stall_c;
    logic             accept_c;
    logic             beat_last_c;
    logic             beat_first_c;

    for (genvar r = 0; r < M; r++) begin : g_row
        bm_row_mult #(
            .W             (W),
            .PACKET_LENGTH (PACKET_LENGTH)
        ) u_row (
            .data   (in_data),
            .bm     (in_bm[r*W*W +: W*W]),
            .prod_c (prod_c[r*CW +: CW])
        );
    end

    // Only a finished stripe that cannot leave S1 blocks the input; partial beats always drain.
    assign stall_c      = s1_valid && s1_last && out_valid && !out_ready;
    assign in_ready     = !stall_c;
    assign accept_c     = in_valid && in_ready;
    assign beat_last_c  = (beat_cnt == CNT_W'(K - 1));
    assign beat_first_c = (beat_cnt == '0);
    assign acc_next_c   = s1_first ? s1_prod : (acc ^ s1_prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt       <= '0;
            s1_valid       <= 1'b0;
            s1_last        <= 1'b0;
            s1_first       <= 1'b0;
            s1_prod        <= '0;
            acc            <= '0;
            out_valid      <= 1'b0;
            out_parity     <= '0;
            out_stripe_cnt <= '0;
        end else begin
            if (accept_c) begin
                beat_cnt <= beat_last_c ? '0 : beat_cnt + CNT_W'(1);
            end

            if (!stall_c) begin
                s1_valid <= accept_c;
                if (accept_c) begin
                    s1_prod  <= prod_c;
                    s1_last  <= beat_last_c;
                    s1_first <= beat_first_c;
                end
            end

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // A new result loading in the handshake cycle keeps out_valid high.
            if (s1_valid && !stall_c) begin
                if (s1_last) begin
                    out_parity     <= acc_next_c;
                    out_valid      <= 1'b1;
                    out_stripe_cnt <= out_stripe_cnt + 16'd1;
                end else begin
                    acc <= acc_next_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_bm_stripe_encoder.sv
// Directed and randomised-stream checks of bm_stripe_encoder against a software bitmatrix model.
module tb_bm_stripe_encoder;

    localparam int unsigned W  = 8;
    localparam int unsigned PL = 32;
    localparam int unsigned K  = 4;
    localparam int unsigned M  = 2;
    localparam int unsigned CW = W * PL;
    localparam int unsigned BW = M * W * W;
    localparam int unsigned PW = M * CW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_data;
    logic [BW-1:0] in_bm;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_parity;
    logic [15:0]   out_stripe_cnt;

    int checks = 0;
    int errors = 0;

    logic [CW-1:0] d [K];
    logic [BW-1:0] b [K];
    logic [PW-1:0] exp_p;
    logic [PW-1:0] exp_a;
    logic [PW-1:0] exp_q [$];

    bm_stripe_encoder #(
        .W             (W),
        .PACKET_LENGTH (PL),
        .K             (K),
        .M             (M)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_bm          (in_bm),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_parity     (out_parity),
        .out_stripe_cnt (out_stripe_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [PW-1:0] model(input logic [CW-1:0] dd, input logic [BW-1:0] bb);
        logic [PW-1:0] p;
        p = '0;
        for (int r = 0; r < M; r++)
            for (int j = 0; j < W; j++)
                for (int i = 0; i < W; i++)
                    if (bb[(r*W+j)*W+i]) p[(r*W+j)*PL +: PL] ^= dd[i*PL +: PL];
        return p;
    endfunction

    function automatic logic [CW-1:0] rand_chunk();
        logic [CW-1:0] v;
        for (int i = 0; i < CW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [BW-1:0] rand_bm();
        logic [BW-1:0] v;
        for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Randomise d/b and return the expected stripe parity.
    task automatic rand_stripe(output logic [PW-1:0] e);
        e = '0;
        for (int k = 0; k < K; k++) begin
            d[k] = rand_chunk();
            b[k] = rand_bm();
            e ^= model(d[k], b[k]);
        end
    endtask

    task automatic send_beats(input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = d[k];
            in_bm    = b[k];
            check("in_ready_beat", PW'(in_ready), PW'(1'b1));
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [CW-1:0] dd;
        logic [BW-1:0] bb;
        logic [PW-1:0] acc_m;
        int            rcv;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_bm     = '0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        check("rst_out_valid", PW'(out_valid), PW'(1'b0));
        check("rst_parity", out_parity, '0);
        check("rst_cnt", PW'(out_stripe_cnt), PW'(16'd0));
        check("rst_in_ready", PW'(in_ready), PW'(1'b1));

        // Identity bitmatrix, device k packets = 1<<k
        for (int k = 0; k < K; k++) begin
            b[k] = '0;
            for (int r = 0; r < M; r++)
                for (int j = 0; j < W; j++) b[k][(r*W+j)*W+j] = 1'b1;
            d[k] = {W{32'h1 << k}};
        end
        send_beats(K);
        check("id_latency_1", PW'(out_valid), PW'(1'b0));
        step();
        check("id_latency_2", PW'(out_valid), PW'(1'b1));
        check("id_parity", out_parity, {(M*W){32'h0000000F}});
        check("id_cnt", PW'(out_stripe_cnt), PW'(16'd1));
        step();
        check("id_handshake_clear", PW'(out_valid), PW'(1'b0));

        // All-zero bitmatrix
        for (int k = 0; k < K; k++) begin
            d[k] = rand_chunk();
            b[k] = '0;
        end
        send_beats(K);
        step();
        check("zero_valid", PW'(out_valid), PW'(1'b1));
        check("zero_parity", out_parity, '0);
        check("zero_cnt", PW'(out_stripe_cnt), PW'(16'd2));
        step();

        // Single coefficient r=1, j=3, i=5 on device 2 only
        for (int k = 0; k < K; k++) begin
            d[k] = rand_chunk();
            b[k] = '0;
        end
        b[2][93] = 1'b1;
        exp_p = '0;
        exp_p[352 +: 32] = d[2][160 +: 32];
        send_beats(K);
        step();
        check("single_valid", PW'(out_valid), PW'(1'b1));
        check("single_parity", out_parity, exp_p);
        check("single_cnt", PW'(out_stripe_cnt), PW'(16'd3));
        step();

        // Backpressure: stripe A held, stripe B stalls in S1
        out_ready = 1'b0;
        rand_stripe(exp_a);
        send_beats(K);
        step();
        check("bp_a_valid", PW'(out_valid), PW'(1'b1));
        check("bp_a_parity", out_parity, exp_a);
        check("bp_a_cnt", PW'(out_stripe_cnt), PW'(16'd4));
        rand_stripe(exp_p);
        send_beats(K);
        check("bp_stall_ready", PW'(in_ready), PW'(1'b0));
        check("bp_stall_parity", out_parity, exp_a);
        step();
        step();
        check("bp_hold_ready", PW'(in_ready), PW'(1'b0));
        check("bp_hold_valid", PW'(out_valid), PW'(1'b1));
        check("bp_hold_parity", out_parity, exp_a);
        check("bp_hold_cnt", PW'(out_stripe_cnt), PW'(16'd4));
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", PW'(in_ready), PW'(1'b1));
        step();
        check("bp_b_valid", PW'(out_valid), PW'(1'b1));
        check("bp_b_parity", out_parity, exp_p);
        check("bp_b_cnt", PW'(out_stripe_cnt), PW'(16'd5));
        check("bp_b_ready", PW'(in_ready), PW'(1'b1));
        step();
        check("bp_b_clear", PW'(out_valid), PW'(1'b0));

        // Reset mid-stripe discards partial work
        rand_stripe(exp_p);
        send_beats(2);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", PW'(out_valid), PW'(1'b0));
        check("mid_rst_parity", out_parity, '0);
        check("mid_rst_cnt", PW'(out_stripe_cnt), PW'(16'd0));
        step();
        rst = 1'b0;
        step();
        check("mid_rst_ready", PW'(in_ready), PW'(1'b1));
        rand_stripe(exp_p);
        send_beats(K);
        step();
        check("post_rst_valid", PW'(out_valid), PW'(1'b1));
        check("post_rst_parity", out_parity, exp_p);
        check("post_rst_cnt", PW'(out_stripe_cnt), PW'(16'd1));
        step();

        // Random bubbles and backpressure over 100 stripes
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        rcv = 0;
        fork
            begin
                for (int s = 0; s < 100; s++) begin
                    acc_m = '0;
                    for (int k = 0; k < K; k++) begin
                        bit acc_ok;
                        int n;
                        dd      = rand_chunk();
                        bb      = rand_bm();
                        acc_m  ^= model(dd, bb);
                        in_data = dd;
                        in_bm   = bb;
                        acc_ok  = 1'b0;
                        n       = 0;
                        while (!acc_ok && n < 1000) begin
                            in_valid = ($urandom_range(0, 3) != 0);
                            @(negedge clk);
                            acc_ok = in_valid && in_ready;
                            @(posedge clk);
                            #1;
                            n++;
                        end
                        if (!acc_ok) check("rand_accept_timeout", PW'(1'b0), PW'(1'b1));
                        if (k == K - 1) exp_q.push_back(acc_m);
                    end
                end
                in_valid = 1'b0;
            end
            begin
                int cyc;
                cyc = 0;
                while (rcv < 100 && cyc < 20000) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("rand_unexpected_result", PW'(1'b1), PW'(1'b0));
                        end else begin
                            check("rand_parity", out_parity, exp_q.pop_front());
                            check("rand_cnt", PW'(out_stripe_cnt), PW'(16'(rcv + 1)));
                        end
                        rcv++;
                    end
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                    cyc++;
                end
            end
        join
        check("rand_received", PW'(rcv), PW'(100));
        check("rand_final_cnt", PW'(out_stripe_cnt), PW'(16'd100));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
